mux_2x1: RTL and testbench



---
 rtl/mux_2x1.sv | 36 +++
 tb/tb_mux_2x1.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_2x1.sv
// Registered 2-to-1 word multiplexer with a valid qualifier.
// One cycle of latency, no backpressure: a new word can be accepted every cycle.
module mux_2x1 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   // The whole word comes from one source. An X/Z sel fails the if test,
   // so simulation falls back to in0.
   logic [WIDTH-1:0] sel_word;

   always_comb begin
      if (sel) sel_word = in1;
      else     sel_word = in0;
   end

   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out <= sel_word;
      end
   end

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: directed test-plan steps plus random
// stimulus compared against a behavioural model, at WIDTH 4 and 16.
module tb_mux_2x1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, sel;
   logic [3:0]  in0, in1;
   logic [3:0]  out;
   logic        out_valid;

   logic        w_rst, w_in_valid, w_sel;
   logic [15:0] w_in0, w_in1;
   logic [15:0] w_out;
   logic        w_out_valid;

   mux_2x1 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel),
      .in_valid(in_valid), .out(out), .out_valid(out_valid)
   );

   mux_2x1 #(.WIDTH(16)) dut_w (
      .clk(clk), .rst(w_rst), .in0(w_in0), .in1(w_in1), .sel(w_sel),
      .in_valid(w_in_valid), .out(w_out), .out_valid(w_out_valid)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: what out / out_valid must hold after each edge.
   logic [15:0] m_out;
   logic        m_valid;
   logic [15:0] mw_out;
   logic        mw_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs to the 4-bit DUT, advance the model, compare after the edge.
   task automatic step(input logic r, input logic v, input logic s,
                       input logic [3:0] a, input logic [3:0] b);
      rst = r; in_valid = v; sel = s; in0 = a; in1 = b;
      @(posedge clk);
      #1;
      if (r) begin
         m_out = 16'h0; m_valid = 1'b0;
      end else if (v) begin
         m_out = {12'h0, (s ? b : a)}; m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      check("model_out", {60'h0, out}, {48'h0, m_out});
      check("model_valid", {63'h0, out_valid}, {63'h0, m_valid});
   endtask

   task automatic step_w(input logic r, input logic v, input logic s,
                         input logic [15:0] a, input logic [15:0] b);
      w_rst = r; w_in_valid = v; w_sel = s; w_in0 = a; w_in1 = b;
      @(posedge clk);
      #1;
      if (r) begin
         mw_out = 16'h0; mw_valid = 1'b0;
      end else if (v) begin
         mw_out = s ? b : a; mw_valid = 1'b1;
      end else begin
         mw_valid = 1'b0;
      end
      check("w_model_out", {48'h0, w_out}, {48'h0, mw_out});
      check("w_model_valid", {63'h0, w_out_valid}, {63'h0, mw_valid});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;
      w_rst = 1'b1; w_in_valid = 1'b0; w_sel = 1'b0; w_in0 = '0; w_in1 = '0;
      m_out = '0; m_valid = 1'b0; mw_out = '0; mw_valid = 1'b0;
      @(negedge clk);

      // Reset wins over in_valid for two edges
      step(1, 1, 0, 4'hA, 4'h5);
      check("reset1_out", {60'h0, out}, 64'h0);
      check("reset1_valid", {63'h0, out_valid}, 64'h0);
      step(1, 1, 1, 4'hA, 4'h5);
      check("reset2_out", {60'h0, out}, 64'h0);
      check("reset2_valid", {63'h0, out_valid}, 64'h0);

      // Basic select
      step(0, 1, 0, 4'h0, 4'hF);
      check("sel0_out", {60'h0, out}, 64'h0);
      check("sel0_valid", {63'h0, out_valid}, 64'h1);
      step(0, 1, 1, 4'h0, 4'hF);
      check("sel1_out", {60'h0, out}, 64'hF);

      // Alternating back-to-back accepts
      step(0, 1, 0, 4'hA, 4'h5);
      check("alt_a_out", {60'h0, out}, 64'hA);
      check("alt_a_valid", {63'h0, out_valid}, 64'h1);
      step(0, 1, 1, 4'hA, 4'h5);
      check("alt_5_out", {60'h0, out}, 64'h5);
      check("alt_5_valid", {63'h0, out_valid}, 64'h1);
      step(0, 1, 0, 4'hC, 4'h3);
      check("alt_c_out", {60'h0, out}, 64'hC);
      check("alt_c_valid", {63'h0, out_valid}, 64'h1);
      step(0, 1, 1, 4'hC, 4'h3);
      check("alt_3_out", {60'h0, out}, 64'h3);
      check("alt_3_valid", {63'h0, out_valid}, 64'h1);

      // Hold while idle
      step(0, 0, 0, 4'h9, 4'h6);
      check("hold_out", {60'h0, out}, 64'h3);
      check("hold_valid", {63'h0, out_valid}, 64'h0);
      step(0, 0, 1, 4'h9, 4'h6);
      check("hold2_out", {60'h0, out}, 64'h3);

      // Equal inputs give the same word for either sel
      step(0, 1, 0, 4'hB, 4'hB);
      check("eq0_out", {60'h0, out}, 64'hB);
      step(0, 1, 1, 4'hB, 4'hB);
      check("eq1_out", {60'h0, out}, 64'hB);

      // Reset mid-stream, then a normal accept
      step(0, 1, 1, 4'h0, 4'hF);
      check("pre_rst_out", {60'h0, out}, 64'hF);
      step(1, 1, 1, 4'h0, 4'hF);
      check("mid_rst_out", {60'h0, out}, 64'h0);
      check("mid_rst_valid", {63'h0, out_valid}, 64'h0);
      step(0, 1, 0, 4'h7, 4'h2);
      check("post_rst_out", {60'h0, out}, 64'h7);
      check("post_rst_valid", {63'h0, out_valid}, 64'h1);

      // Random stimulus against the model
      for (int i = 0; i < 300; i++) begin
         logic [3:0] a, b;
         a = 4'($urandom);
         b = ($urandom_range(0, 7) == 0) ? a : 4'($urandom);
         step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), a, b);
      end

      // 16-bit instance
      step_w(1, 1, 1, 16'h1234, 16'hABCD);
      check("w_reset_out", {48'h0, w_out}, 64'h0);
      step_w(0, 1, 1, 16'h1234, 16'hABCD);
      check("w_sel1_out", {48'h0, w_out}, 64'hABCD);
      check("w_sel1_valid", {63'h0, w_out_valid}, 64'h1);
      step_w(0, 1, 0, 16'h1234, 16'hABCD);
      check("w_sel0_out", {48'h0, w_out}, 64'h1234);
      step_w(0, 0, 1, 16'hFFFF, 16'h0000);
      check("w_hold_out", {48'h0, w_out}, 64'h1234);
      for (int i = 0; i < 100; i++) begin
         step_w(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
